cordic_engine: RTL

CORDIC_ENGINE -- requirements
Module: cordic_engine

---
 rtl/cordic_engine.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: rotation (cos/sin) and vectoring (magnitude/atan).
// One micro-rotation per cycle on WIDTH+2 bit datapath, saturated outputs.
module cordic_engine #(
    parameter int WIDTH = 18,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             ready,
    output logic             out_valid,
    output logic             ovf,
    output logic             err
);

    localparam int IW = WIDTH + 2;
    localparam int SH = 32 - WIDTH;
    localparam logic [63:0] HALF = (SH == 0) ? 64'd0 : (64'd1 << (SH - 1));
    localparam logic [4:0] LAST = 5'(ITER - 1);
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    // atan(2^-i) in Q2.30, rounded to nearest; i >= 10 is exactly 2^(30-i)
    function automatic logic [31:0] atan_q30(input logic [4:0] i);
        case (i)
            5'd0:    return 32'h3243F6A9;
            5'd1:    return 32'h1DAC6705;
            5'd2:    return 32'h0FADBAFD;
            5'd3:    return 32'h07F56EA7;
            5'd4:    return 32'h03FEAB77;
            5'd5:    return 32'h01FFD55C;
            5'd6:    return 32'h00FFFAAB;
            5'd7:    return 32'h007FFF55;
            5'd8:    return 32'h003FFFEB;
            5'd9:    return 32'h001FFFFD;
            default: return (i <= 5'd29) ? (32'd1 << (5'd30 - i)) : 32'd0;
        endcase
    endfunction

    // Q2.30 -> Q2.(WIDTH-2), round half up
    function automatic logic signed [IW-1:0] to_fix(input logic [31:0] v);
        logic [63:0] t;
        t = ({32'd0, v} + HALF) >> SH;
        return IW'(t);
    endfunction

    function automatic logic [WIDTH:0] sat(input logic signed [IW-1:0] v);
        if (&v[IW-1:WIDTH-1] || ~|v[IW-1:WIDTH-1])
            return {1'b0, v[WIDTH-1:0]};
        return {1'b1, v[IW-1] ? MINV : MAXV};
    endfunction

    localparam logic signed [IW-1:0] KC  = to_fix(32'd652032874);
    localparam logic signed [IW-1:0] HPI = to_fix(atan_q30(5'd0)) <<< 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;
    logic [4:0] cnt_q;
    logic       mode_q, err_q;
    logic       accept, dpos, op_err;
    logic signed [IW-1:0] x_q, y_q, z_q;
    logic signed [IW-1:0] x_it, y_it, z_it;
    logic signed [IW-1:0] xs, ys, at;
    logic signed [IW-1:0] x_ext, y_ext, z_ext;
    logic [WIDTH:0] x_sat, y_sat, z_sat;

    assign ready  = (state_q == IDLE) && !out_valid;
    assign accept = start && ready;

    assign x_ext = {{2{x_in[WIDTH-1]}}, x_in};
    assign y_ext = {{2{y_in[WIDTH-1]}}, y_in};
    assign z_ext = {{2{z_in[WIDTH-1]}}, z_in};

    assign op_err = mode ? x_in[WIDTH-1] : ((z_ext > HPI) || (z_ext < -HPI));

    assign xs   = x_q >>> cnt_q;
    assign ys   = y_q >>> cnt_q;
    assign at   = to_fix(atan_q30(cnt_q));
    // d = +1: rotation drives z toward 0, vectoring drives y toward 0
    assign dpos = mode_q ? y_q[IW-1] : ~z_q[IW-1];

    assign x_it = dpos ? (x_q - ys) : (x_q + ys);
    assign y_it = dpos ? (y_q + xs) : (y_q - xs);
    assign z_it = dpos ? (z_q - at) : (z_q + at);

    assign x_sat = sat(x_q);
    assign y_sat = sat(y_q);
    assign z_sat = sat(z_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            err_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    cnt_q  <= '0;
                    mode_q <= mode;
                    err_q  <= op_err;
                    x_q    <= mode ? x_ext : KC;
                    y_q    <= mode ? y_ext : '0;
                    z_q    <= mode ? '0 : z_ext;
                end
                RUN: begin
                    x_q   <= x_it;
                    y_q   <= y_it;
                    z_q   <= z_it;
                    cnt_q <= (cnt_q == LAST) ? 5'd0 : cnt_q + 5'd1;
                end
                DONE: begin
                    x_out     <= x_sat[WIDTH-1:0];
                    y_out     <= y_sat[WIDTH-1:0];
                    z_out     <= z_sat[WIDTH-1:0];
                    ovf       <= x_sat[WIDTH] | y_sat[WIDTH] | z_sat[WIDTH];
                    err       <= err_q;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
